// File: rtl/innerproduct_seq.sv
// Sequential inner product: streams N_FEAT feature words and multiplies each by its
// THETA coefficient, which is read from an external table indexed by theta_addr.
// The wrapped 32-bit sum is presented on a valid/ready output port.
module innerproduct_seq #(
  parameter int unsigned        N_FEAT    = 41,
  parameter logic [N_FEAT-1:0]  SKIP_MASK = N_FEAT'(41'h2)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        x_valid,
  input  logic [31:0] x_data,
  output logic        x_ready,
  output logic [5:0]  theta_addr,
  input  logic [31:0] theta_data,
  input  logic        abort,
  output logic        h_valid,
  output logic [31:0] h_data,
  input  logic        h_ready,
  output logic        busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;
  localparam logic [AW-1:0] K_LAST   = AW'(N_FEAT - 1);
  // Widened to 64 entries so that any 6-bit counter value is a legal index.
  localparam logic [63:0]   SKIP_EXT = 64'(SKIP_MASK);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_OUT     = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] h_data_q, h_data_d;
  logic          h_valid_q, h_valid_d;
  logic          x_ready_q, x_ready_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] term_c;
  logic [DW-1:0] sum_c;

  // Per-feature term: the bias slot takes THETA[0] alone; masked features contribute zero.
  always_comb begin
    term_c = '0;
    if (k_q == '0) begin
      term_c = theta_data;
    end else if (SKIP_EXT[k_q]) begin
      term_c = '0;
    end else begin
      term_c = x_data * theta_data;
    end
    sum_c = ((k_q == '0) ? DW'(0) : acc_q) + term_c;
  end

  // Next-state logic: collect features, then hold the result until it is taken.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    h_data_d  = h_data_q;
    h_valid_d = h_valid_q;
    case (state_q)
      ST_COLLECT: begin
        if (abort) begin
          k_d   = '0;
          acc_d = '0;
        end else if (x_valid && x_ready_q) begin
          acc_d = sum_c;
          if (k_q == K_LAST) begin
            k_d       = '0;
            h_data_d  = sum_c;
            h_valid_d = 1'b1;
            state_d   = ST_OUT;
          end else begin
            k_d = k_q + AW'(1);
          end
        end
      end
      ST_OUT: begin
        if (h_ready) begin
          h_valid_d = 1'b0;
          state_d   = ST_COLLECT;
        end
      end
    endcase
    x_ready_d = (state_d == ST_COLLECT);
    busy_d    = (k_d != '0) || (state_d == ST_OUT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_COLLECT;
      k_q       <= '0;
      acc_q     <= '0;
      h_data_q  <= '0;
      h_valid_q <= 1'b0;
      x_ready_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      h_data_q  <= h_data_d;
      h_valid_q <= h_valid_d;
      x_ready_q <= x_ready_d;
      busy_q    <= busy_d;
    end
  end

  assign x_ready    = x_ready_q;
  assign theta_addr = k_q;
  assign h_valid    = h_valid_q;
  assign h_data     = h_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_innerproduct_seq.sv
// Self-checking bench for innerproduct_seq with a result scoreboard.
module tb_innerproduct_seq;

  localparam int unsigned N = 41;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        x_valid = 1'b0;
  logic [31:0] x_data = '0;
  logic        x_ready;
  logic [5:0]  theta_addr;
  logic [31:0] theta_data;
  logic        abort = 1'b0;
  logic        h_valid;
  logic [31:0] h_data;
  logic        h_ready = 1'b1;
  logic        busy;

  logic [31:0] theta_mem [64];
  logic [31:0] xv [64];
  logic [31:0] sb [$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_acc = 0;

  innerproduct_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x_valid    (x_valid),
    .x_data     (x_data),
    .x_ready    (x_ready),
    .theta_addr (theta_addr),
    .theta_data (theta_data),
    .abort      (abort),
    .h_valid    (h_valid),
    .h_data     (h_data),
    .h_ready    (h_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign theta_data = theta_mem[theta_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: bias slot is THETA[0]; default mask drops feature 1.
  function automatic logic [31:0] model_sum();
    logic [N-1:0] skip = N'(41'h2);
    logic [31:0]  s    = theta_mem[0];
    for (int k = 1; k < N; k++) begin
      if (!skip[k]) s = s + xv[k] * theta_mem[k];
    end
    return s;
  endfunction

  // Result monitor: every h transfer pops one expected value.
  always @(negedge clk) begin
    if (rst_n && h_valid && h_ready) begin
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
      else check("h_data", h_data, sb.pop_front());
    end
  end

  // Offer `count` features with random bubbles; push the expected result if requested.
  task automatic drive(input int count, input int bubble_pct, input logic push_exp,
                       input logic [31:0] exp);
    int   idx   = 0;
    int   guard = 0;
    logic acc;
    while (idx < count && guard < 5000) begin
      x_valid = ($urandom_range(99) >= 32'(bubble_pct));
      x_data  = xv[idx];
      @(negedge clk);
      check("theta_addr", 32'(theta_addr), 32'(idx));
      acc = x_valid && x_ready;
      if (acc && idx == 0) first_acc = cyc;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    x_valid = 1'b0;
    if (idx < count) check("drive_timeout", 32'(idx), 32'(count));
    if (push_exp) sb.push_back(exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 64; k++) begin
      theta_mem[k] = 32'd1;
      xv[k]        = 32'(k);
    end
  endtask

  initial begin
    load_ramp();
    // Reset values
    wait_cycles(2);
    check("rst_h_valid", 32'(h_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_theta_addr", 32'(theta_addr), 32'd0);
    check("rst_h_data", h_data, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    wait_cycles(1);
    check("rst_x_ready", 32'(x_ready), 32'd1);

    // Ramp vector, no bubbles: 820 after 41 cycles, one-cycle pulse
    drive(N, 0, 1'b1, 32'd820);
    check("t1_h_valid", 32'(h_valid), 32'd1);
    check("t1_latency", 32'(cyc - first_acc), 32'd41);
    check("t1_x_ready_out", 32'(x_ready), 32'd0);
    wait_cycles(1);
    check("t1_h_pulse", 32'(h_valid), 32'd0);
    check("t1_x_ready", 32'(x_ready), 32'd1);

    // Wrap: THETA0=0, x=all ones
    theta_mem[0] = 32'd0;
    for (int k = 0; k < 64; k++) xv[k] = 32'hFFFF_FFFF;
    drive(N, 0, 1'b1, 32'hFFFF_FFD9);
    wait_cycles(2);
    load_ramp();

    // Back-pressure in OUT; x_valid and abort must be ignored
    h_ready = 1'b0;
    drive(N, 0, 1'b1, 32'd820);
    x_valid = 1'b1;
    abort   = 1'b1;
    x_data  = 32'd123;
    for (int i = 0; i < 5; i++) begin
      wait_cycles(1);
      check("t3_h_valid", 32'(h_valid), 32'd1);
      check("t3_h_data", h_data, 32'd820);
      check("t3_x_ready", 32'(x_ready), 32'd0);
      check("t3_theta_addr", 32'(theta_addr), 32'd0);
      check("t3_busy", 32'(busy), 32'd1);
    end
    x_valid = 1'b0;
    abort   = 1'b0;
    h_ready = 1'b1;
    wait_cycles(1);
    check("t3_h_valid_drop", 32'(h_valid), 32'd0);
    check("t3_x_ready", 32'(x_ready), 32'd1);
    check("t3_busy_idle", 32'(busy), 32'd0);

    // Abort after 20 features, with a simultaneous offered word
    drive(20, 0, 1'b0, 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_k20", 32'(theta_addr), 32'd20);
    abort   = 1'b1;
    x_valid = 1'b1;
    x_data  = xv[20];
    wait_cycles(1);
    abort   = 1'b0;
    x_valid = 1'b0;
    check("t4_k_cleared", 32'(theta_addr), 32'd0);
    check("t4_busy_cleared", 32'(busy), 32'd0);
    drive(N, 0, 1'b1, 32'd820);
    wait_cycles(2);

    // 50% bubbles
    drive(N, 50, 1'b1, 32'd820);
    wait_cycles(2);

    // Random coefficients and data against the reference model
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 64; k++) begin
        theta_mem[k] = $urandom;
        xv[k]        = $urandom;
      end
      drive(N, 30, 1'b1, model_sum());
      wait_cycles(2);
    end
    load_ramp();

    // Asynchronous reset at k=30
    drive(30, 0, 1'b0, 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check("t7_h_valid", 32'(h_valid), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_theta_addr", 32'(theta_addr), 32'd0);
    check("t7_h_data", h_data, 32'd0);
    check("t7_x_ready", 32'(x_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    wait_cycles(1);
    drive(N, 0, 1'b1, 32'd820);
    wait_cycles(2);

    // Reset while holding a result: it must never be emitted
    h_ready = 1'b0;
    drive(N, 0, 1'b1, 32'd820);
    check("t8_h_valid_held", 32'(h_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t8_h_valid_rst", 32'(h_valid), 32'd0);
    sb.delete(sb.size() - 1);
    @(negedge clk) rst_n = 1'b1;
    h_ready = 1'b1;
    wait_cycles(3);
    check("t8_no_emit", 32'(h_valid), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
